pixel_frame_sequencer: RTL and testbench
========================================

// Module: pixel_frame_sequencer
// PURPOSE
// - Frame-level controller for the 2x2 pixel array: erase -> expose -> convert -> read out.
// - Drives the erase/expose/convert/read strobes and the gates for the analog bias and ramp.
// - Generates the digital ramp code that pixel comparators latch during convert.
// - Returns the four pixel codes over a valid/ready stream.
// - Sits between the top-level frame request and the pixel array bus; replaces the free-running FSM.
// PARAMETERS
// - ERASE_CYCLES  5  cycles erase is held high (>=1)
// - EXP_W         16 width of expose_cycles input
// - RAMP_W        8  ramp/data width; convert lasts 2**RAMP_W cycles
// - NUM_PIX       4  pixels read per frame (width of read strobe)
// PORTS
// - clk            in   1          clock
// - reset          in   1          asynchronous, active-high
// - start          in   1          frame request; sampled only in IDLE
// - abort          in   1          synchronous abort, any state
// - expose_cycles  in   EXP_W      exposure length; latched at accepted start
// - busy           out  1          high in every state except IDLE
// - frame_done     out  1          1-cycle pulse after the last pixel handshake
// - erase          out  1          pixel erase strobe
// - expose         out  1          pixel expose strobe; also gates anaBias
// - convert        out  1          convert strobe; also gates anaRamp
// - read           out  NUM_PIX    one-hot pixel read enable
// - ramp_code      out  RAMP_W     digital ramp driven to pixel latches during CONVERT
// - pix_data       in   RAMP_W     shared pixel data bus, valid while read[i]=1
// - out_data       out  RAMP_W     captured pixel code
// - out_idx        out  2          pixel index of out_data
// - out_valid      out  1          stream valid
// - out_ready      in   1          stream ready
// BEHAVIOUR
// - Reset (async): state IDLE; all outputs 0; latched exposure = 1.
// - All outputs are registered. erase/expose/convert/any read bit are mutually exclusive.
// - FSM states: IDLE, ERASE, EXPOSE, CONVERT, READ, HOLD, DONE.
// - IDLE: start=1 at edge k -> ERASE. Latch expose_cycles; a value of 0 is treated as 1.
// - Accepted start at edge k gives:
//   - erase high cycles k+1..k+ERASE_CYCLES.
//   - expose high for the next N cycles.
//   - convert high for the next 2**RAMP_W cycles.
//   - No gap cycles between phases.
// - CONVERT: ramp_code = 0 on the first convert cycle, +1 per cycle, ends at 2**RAMP_W-1.
//   - Never wraps. Held at 0 outside CONVERT.
// - READ(i), i = 0..NUM_PIX-1:
//   - read[i] high for exactly 1 cycle.
//   - pix_data captured into out_data at the end of that cycle; out_idx = i.
//   - Next cycle -> HOLD with out_valid = 1.
// - HOLD:
//   - out_valid and out_data stay stable until out_ready = 1.
//   - On the handshake edge, out_valid drops and the FSM moves to READ(i+1), or to DONE after the last pixel.
//   - No read strobe is asserted while in HOLD (backpressure stalls the array, never drops data).
// - DONE: frame_done = 1 for one cycle -> IDLE; busy = 0 from the next cycle.
// - start while busy: ignored, not queued.
// - start asserted in the DONE cycle: ignored; must be re-asserted in IDLE.
// - abort = 1, any non-IDLE state:
//   - Next state IDLE; all strobes, out_valid and ramp_code = 0 next cycle; no frame_done.
//   - abort has priority over start and over the handshake.
// - Reset mid-frame: outputs 0 immediately (async); no partial frame resumes.
// - Phase counters are down-counters: load the length, then done at count 1.
//   - Widths: max(EXP_W, RAMP_W+1) bits.
// STRUCTURE
// - pixel_ctrl_pkg holds: state_t enum, RAMP_W/NUM_PIX defaults, and the onehot_read(idx) function.
// - One sub-module, phase_timer: load/len/tick -> done.
//   - Shared by ERASE, EXPOSE and CONVERT; reloaded on each phase entry.
// - The top-level pixel wrapper gates its analog lines with expose/convert and drives DATA from ramp_code.
// TESTING
// - Reset, then start with expose_cycles = 3, out_ready = 1 ->
//   - erase 5 cycles, expose 3, convert 256, read strobes 0001, 0010, 0100, 1000.
//   - out_idx 0..3 in order; frame_done exactly once.
// - Pixel model latches ramp_code at codes 10, 50, 200, 255 -> out_data = 10, 50, 200, 255.
// - out_ready low 7 cycles on pixel 1 -> out_valid/out_data held; read[2] not asserted until the cycle after the handshake.
// - expose_cycles = 0 -> expose high exactly 1 cycle. start pulsed during CONVERT -> no second frame.
// - abort in EXPOSE and again in HOLD -> all outputs 0 next cycle, busy = 0, no frame_done.
//   - A new start then runs a full frame.
// - Async reset asserted mid-CONVERT -> all outputs 0 before the next edge; ramp_code = 0.

Source files
------------

// File: rtl/pixel_ctrl_pkg.sv
// pixel_ctrl_pkg: shared types and helpers for the pixel frame sequencer.
//   state_t       frame FSM state encoding
//   *_DEFAULT     default ramp width and pixel count
//   onehot_read   pixel index -> one-hot read strobe
package pixel_ctrl_pkg;

    localparam int RAMP_W_DEFAULT  = 8;
    localparam int NUM_PIX_DEFAULT = 4;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ERASE   = 3'd1,
        S_EXPOSE  = 3'd2,
        S_CONVERT = 3'd3,
        S_READ    = 3'd4,
        S_HOLD    = 3'd5,
        S_DONE    = 3'd6
    } state_t;

    // Returns a full 32-bit vector; callers cast it to their strobe width.
    function automatic logic [31:0] onehot_read(input logic [1:0] idx);
        return 32'd1 << idx;
    endfunction

endpackage

// File: rtl/phase_timer.sv
// phase_timer: down-counter shared by the ERASE, EXPOSE and CONVERT phases.
//   clk, reset   clock, async active-high reset
//   load_i       load len_i (phase entry); takes priority over tick_i
//   len_i        phase length in cycles (>=1)
//   tick_i       count down one cycle
//   done_o       high during the last cycle of the phase (count == 1)
module phase_timer #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_i,
    input  logic [CNT_W-1:0] len_i,
    input  logic             tick_i,
    output logic             done_o
);

    logic [CNT_W-1:0] count_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else if (load_i) begin
            count_q <= len_i;
        end else if (tick_i && count_q > CNT_W'(1)) begin
            // Parks at 1 rather than wrapping; the next phase entry reloads it.
            count_q <= count_q - CNT_W'(1);
        end
    end

    assign done_o = (count_q == CNT_W'(1));

endmodule

// File: rtl/pixel_frame_sequencer.sv
// pixel_frame_sequencer: frame controller for the 2x2 pixel array.
// Runs erase -> expose -> convert -> read out, producing the ramp code during
// convert and streaming the captured pixel codes over valid/ready.
//   clk, reset       clock, async active-high reset
//   start, abort     frame request (IDLE only) / synchronous abort
//   expose_cycles    exposure length, latched on accepted start (0 -> 1)
//   busy, frame_done status; frame_done pulses after the last handshake
//   erase/expose/convert/read   pixel strobes (expose/convert also gate
//                    the analog bias/ramp in the pixel wrapper)
//   ramp_code        digital ramp driven to the pixel latches
//   pix_data         shared pixel data bus
//   out_*            captured pixel code stream
module pixel_frame_sequencer
    import pixel_ctrl_pkg::*;
#(
    parameter int ERASE_CYCLES = 5,
    parameter int EXP_W        = 16,
    parameter int RAMP_W       = RAMP_W_DEFAULT,
    parameter int NUM_PIX      = NUM_PIX_DEFAULT
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               abort,
    input  logic [EXP_W-1:0]   expose_cycles,
    output logic               busy,
    output logic               frame_done,
    output logic               erase,
    output logic               expose,
    output logic               convert,
    output logic [NUM_PIX-1:0] read,
    output logic [RAMP_W-1:0]  ramp_code,
    input  logic [RAMP_W-1:0]  pix_data,
    output logic [RAMP_W-1:0]  out_data,
    output logic [1:0]         out_idx,
    output logic               out_valid,
    input  logic               out_ready
);

    localparam int CNT_W = (EXP_W > RAMP_W + 1) ? EXP_W : RAMP_W + 1;

    state_t             state_q, state_d;
    logic [EXP_W-1:0]   exp_q, exp_d;
    logic [1:0]         idx_q, idx_d;
    logic [RAMP_W-1:0]  ramp_q, ramp_d;
    logic [RAMP_W-1:0]  out_data_q, out_data_d;
    logic [1:0]         out_idx_q, out_idx_d;
    logic               out_valid_q, out_valid_d;
    logic               busy_q, done_q, erase_q, expose_q, convert_q;
    logic [NUM_PIX-1:0] read_q;

    logic               t_load, t_tick, t_done;
    logic [CNT_W-1:0]   t_len;

    phase_timer #(.CNT_W(CNT_W)) u_timer (
        .clk    (clk),
        .reset  (reset),
        .load_i (t_load),
        .len_i  (t_len),
        .tick_i (t_tick),
        .done_o (t_done)
    );

    assign t_tick = (state_q == S_ERASE) || (state_q == S_EXPOSE) || (state_q == S_CONVERT);

    always_comb begin
        state_d     = state_q;
        exp_d       = exp_q;
        idx_d       = idx_q;
        t_load      = 1'b0;
        t_len       = '0;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_idx_d   = out_idx_q;
        case (state_q)
            S_IDLE: if (start && !abort) begin
                state_d = S_ERASE;
                exp_d   = (expose_cycles == '0) ? EXP_W'(1) : expose_cycles;
                t_load  = 1'b1;
                t_len   = CNT_W'(ERASE_CYCLES);
            end
            S_ERASE: if (t_done) begin
                state_d = S_EXPOSE;
                t_load  = 1'b1;
                t_len   = CNT_W'(exp_q);
            end
            S_EXPOSE: if (t_done) begin
                state_d = S_CONVERT;
                t_load  = 1'b1;
                t_len   = CNT_W'(2 ** RAMP_W);
            end
            S_CONVERT: if (t_done) begin
                state_d = S_READ;
                idx_d   = 2'd0;
            end
            S_READ: begin
                // read[i] is high this cycle, so pix_data holds pixel i now.
                state_d     = S_HOLD;
                out_valid_d = 1'b1;
                out_data_d  = pix_data;
                out_idx_d   = idx_q;
            end
            S_HOLD: if (out_ready) begin
                out_valid_d = 1'b0;
                if (int'(idx_q) == NUM_PIX - 1) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_READ;
                    idx_d   = idx_q + 2'd1;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        // Abort wins over everything, including a handshake in HOLD.
        if (abort && state_q != S_IDLE) begin
            state_d     = S_IDLE;
            t_load      = 1'b0;
            out_valid_d = 1'b0;
            out_data_d  = '0;
            out_idx_d   = 2'd0;
        end
    end

    // Ramp restarts at 0 on convert entry and steps once per convert cycle;
    // the phase is exactly 2**RAMP_W long so it tops out without wrapping.
    assign ramp_d = (state_q == S_CONVERT && state_d == S_CONVERT) ? ramp_q + RAMP_W'(1) : '0;

    // Outputs are registered from next state so they line up with state_q.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            exp_q       <= EXP_W'(1);
            idx_q       <= 2'd0;
            ramp_q      <= '0;
            out_data_q  <= '0;
            out_idx_q   <= 2'd0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            erase_q     <= 1'b0;
            expose_q    <= 1'b0;
            convert_q   <= 1'b0;
            read_q      <= '0;
        end else begin
            state_q     <= state_d;
            exp_q       <= exp_d;
            idx_q       <= idx_d;
            ramp_q      <= ramp_d;
            out_data_q  <= out_data_d;
            out_idx_q   <= out_idx_d;
            out_valid_q <= out_valid_d;
            busy_q      <= (state_d != S_IDLE);
            done_q      <= (state_d == S_DONE);
            erase_q     <= (state_d == S_ERASE);
            expose_q    <= (state_d == S_EXPOSE);
            convert_q   <= (state_d == S_CONVERT);
            read_q      <= (state_d == S_READ) ? NUM_PIX'(onehot_read(idx_d)) : '0;
        end
    end

    assign busy       = busy_q;
    assign frame_done = done_q;
    assign erase      = erase_q;
    assign expose     = expose_q;
    assign convert    = convert_q;
    assign read       = read_q;
    assign ramp_code  = ramp_q;
    assign out_data   = out_data_q;
    assign out_idx    = out_idx_q;
    assign out_valid  = out_valid_q;

endmodule

// File: tb/tb_pixel_frame_sequencer.sv
// Directed bench for pixel_frame_sequencer. A four-pixel comparator model
// latches ramp_code at fixed thresholds and drives pix_data on read.
module tb_pixel_frame_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [15:0] expose_cycles = '0;
    logic        busy, frame_done, erase, expose, convert;
    logic [3:0]  read;
    logic [7:0]  ramp_code, pix_data, out_data;
    logic [1:0]  out_idx;
    logic        out_valid;
    logic        out_ready = 1'b1;

    int checks = 0;
    int passes = 0;

    pixel_frame_sequencer dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .expose_cycles(expose_cycles), .busy(busy), .frame_done(frame_done),
        .erase(erase), .expose(expose), .convert(convert), .read(read),
        .ramp_code(ramp_code), .pix_data(pix_data), .out_data(out_data),
        .out_idx(out_idx), .out_valid(out_valid), .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    // Pixel comparators: each latches the ramp when it crosses its threshold.
    logic [7:0] thr [4] = '{8'd10, 8'd50, 8'd200, 8'd255};
    logic [7:0] lat [4] = '{8'd0, 8'd0, 8'd0, 8'd0};
    always @(posedge clk)
        if (convert)
            for (int i = 0; i < 4; i++)
                if (ramp_code == thr[i]) lat[i] <= ramp_code;
    always_comb begin
        pix_data = 8'h00;
        case (read)
            4'b0001: pix_data = lat[0];
            4'b0010: pix_data = lat[1];
            4'b0100: pix_data = lat[2];
            4'b1000: pix_data = lat[3];
            default: pix_data = 8'h00;
        endcase
    end

    // Frame observation results
    int first_erase, last_erase, n_erase, first_expose, n_expose;
    int first_convert, last_convert, n_convert, ramp_err, excl_err;
    int n_read, n_hs, n_done, done_cyc, stall_cnt, hold_err;
    logic [3:0] rd_seq [4];
    int         rd_cyc [4];
    logic [1:0] hs_idx [4];
    logic [7:0] hs_data [4];
    int         hs_cyc [4];

    task automatic kick(input logic [15:0] e);
        @(negedge clk);
        expose_cycles = e;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Called on the negedge of cycle 1 (first cycle after the start edge).
    // Runs until frame_done (bounded) and ends on the negedge after it.
    task automatic observe_frame(input int stall_pix, input int stall_n, input int start_at);
        int stalled = 0;
        bit prev_stall = 0;
        bit done_seen = 0;
        logic [7:0] prev_data = '0;
        logic [1:0] prev_idx = '0;
        first_erase = -1; last_erase = -1; n_erase = 0; first_expose = -1; n_expose = 0;
        first_convert = -1; last_convert = -1; n_convert = 0; ramp_err = 0; excl_err = 0;
        n_read = 0; n_hs = 0; n_done = 0; done_cyc = -1; stall_cnt = 0; hold_err = 0;
        for (int c = 1; c <= 3000 && !done_seen; c++) begin
            if (erase) begin
                if (first_erase < 0) first_erase = c;
                last_erase = c; n_erase++;
            end
            if (expose) begin
                if (first_expose < 0) first_expose = c;
                n_expose++;
            end
            if (convert) begin
                if (first_convert < 0) first_convert = c;
                last_convert = c; n_convert++;
                if (ramp_code !== 8'(c - first_convert)) ramp_err++;
            end else if (ramp_code !== 8'd0) ramp_err++;
            if (int'(erase) + int'(expose) + int'(convert) + int'(read != 0) > 1 || $countones(read) > 1)
                excl_err++;
            if (read != 0 && n_read < 4) begin
                rd_seq[n_read] = read; rd_cyc[n_read] = c; n_read++;
            end
            if (frame_done) begin n_done++; done_cyc = c; done_seen = 1; end
            if (prev_stall && (!out_valid || out_data !== prev_data || out_idx !== prev_idx || read != 0))
                hold_err++;
            // out_ready chosen here is what the coming edge sees.
            if (out_valid && int'(out_idx) == stall_pix && stalled < stall_n) begin
                out_ready = 1'b0; stalled++;
            end else out_ready = 1'b1;
            prev_stall = out_valid && !out_ready;
            if (prev_stall) stall_cnt++;
            prev_data = out_data; prev_idx = out_idx;
            if (out_valid && out_ready && n_hs < 4) begin
                hs_idx[n_hs] = out_idx; hs_data[n_hs] = out_data; hs_cyc[n_hs] = c; n_hs++;
            end
            start = (c == start_at);
            @(negedge clk);
        end
        start = 1'b0;
        out_ready = 1'b1;
    endtask

    task automatic test_reset();
        #12;
        checks++;
        if ({busy, frame_done, erase, expose, convert, read, ramp_code, out_data, out_idx, out_valid} !== 28'd0)
            $display("FAIL reset_outputs: got %h want 0",
                     {busy, frame_done, erase, expose, convert, read, ramp_code, out_data, out_idx, out_valid});
        else passes++;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_full_frame();
        logic [3:0] exp_rd [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
        logic [7:0] exp_d [4] = '{8'd10, 8'd50, 8'd200, 8'd255};
        kick(16'd3);
        observe_frame(-1, 0, 0);
        checks++; if (first_erase !== 1 || last_erase !== 5 || n_erase !== 5)
            $display("FAIL erase_window: got %0d..%0d n=%0d want 1..5 n=5", first_erase, last_erase, n_erase); else passes++;
        checks++; if (first_expose !== 6 || n_expose !== 3)
            $display("FAIL expose_window: got first=%0d n=%0d want 6 n=3", first_expose, n_expose); else passes++;
        checks++; if (first_convert !== 9 || last_convert !== 264 || n_convert !== 256)
            $display("FAIL convert_window: got %0d..%0d n=%0d want 9..264 n=256", first_convert, last_convert, n_convert); else passes++;
        checks++; if (ramp_err !== 0 || excl_err !== 0)
            $display("FAIL ramp_and_exclusive: got ramp_err=%0d excl_err=%0d want 0 0", ramp_err, excl_err); else passes++;
        checks++; if (n_read !== 4 || n_hs !== 4)
            $display("FAIL read_count: got reads=%0d hs=%0d want 4 4", n_read, n_hs); else passes++;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (rd_seq[i] !== exp_rd[i] || hs_idx[i] !== 2'(i) || hs_data[i] !== exp_d[i])
                $display("FAIL pixel%0d: got read=%b idx=%0d data=%0d want read=%b idx=%0d data=%0d",
                         i, rd_seq[i], hs_idx[i], hs_data[i], exp_rd[i], i, exp_d[i]);
            else passes++;
        end
        checks++; if (rd_cyc[0] !== 265 || n_done !== 1 || done_cyc !== 273)
            $display("FAIL done_timing: got read0=%0d done=%0d@%0d want 265 1@273", rd_cyc[0], n_done, done_cyc); else passes++;
        checks++; if (busy !== 1'b0 || frame_done !== 1'b0)
            $display("FAIL idle_after_done: got busy=%b done=%b want 0 0", busy, frame_done); else passes++;
    endtask

    task automatic test_backpressure();
        kick(16'd3);
        observe_frame(1, 7, 0);
        checks++; if (stall_cnt !== 7 || hold_err !== 0)
            $display("FAIL stall_hold: got stalls=%0d hold_err=%0d want 7 0", stall_cnt, hold_err); else passes++;
        checks++; if (hs_data[1] !== 8'd50 || hs_cyc[1] !== 275)
            $display("FAIL stall_handshake: got data=%0d cyc=%0d want 50 275", hs_data[1], hs_cyc[1]); else passes++;
        checks++; if (rd_cyc[2] !== hs_cyc[1] + 1 || rd_seq[2] !== 4'b0100)
            $display("FAIL read2_after_hs: got cyc=%0d read=%b want %0d 0100", rd_cyc[2], rd_seq[2], hs_cyc[1] + 1); else passes++;
        checks++; if (n_done !== 1 || done_cyc !== 280 || hs_data[3] !== 8'd255)
            $display("FAIL stall_done: got n=%0d cyc=%0d d3=%0d want 1 280 255", n_done, done_cyc, hs_data[3]); else passes++;
    endtask

    task automatic test_zero_expose();
        int extra = 0;
        kick(16'd0);
        observe_frame(-1, 0, 100);  // start pulse lands mid-CONVERT
        checks++; if (n_expose !== 1 || first_expose !== 6 || first_convert !== 7)
            $display("FAIL zero_expose: got n=%0d first=%0d conv=%0d want 1 6 7", n_expose, first_expose, first_convert); else passes++;
        for (int c = 0; c < 20; c++) begin
            if (busy || erase) extra++;
            @(negedge clk);
        end
        checks++; if (extra !== 0 || n_done !== 1)
            $display("FAIL start_while_busy: got busy_cycles=%0d done=%0d want 0 1", extra, n_done); else passes++;
    endtask

    task automatic test_abort();
        int dn = 0, to = 1;
        kick(16'd20);
        for (int c = 0; c < 20; c++) begin
            if (expose) begin to = 0; break; end
            @(negedge clk);
        end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        checks++;
        if (to || {busy, frame_done, erase, expose, convert, read, ramp_code, out_data, out_idx, out_valid} !== 28'd0)
            $display("FAIL abort_expose: got timeout=%0d outs=%h want 0 0", to,
                     {busy, frame_done, erase, expose, convert, read, ramp_code, out_data, out_idx, out_valid});
        else passes++;
        for (int c = 0; c < 10; c++) begin
            if (frame_done || busy) dn++;
            @(negedge clk);
        end
        checks++; if (dn !== 0) $display("FAIL abort_quiet: got %0d active cycles want 0", dn); else passes++;

        out_ready = 1'b0;
        to = 1;
        kick(16'd3);
        for (int c = 0; c < 400; c++) begin
            if (out_valid) begin to = 0; break; end
            @(negedge clk);
        end
        abort = 1'b1;
        out_ready = 1'b1;  // handshake offered in the same cycle; abort must win
        @(negedge clk);
        abort = 1'b0;
        checks++;
        if (to || {busy, frame_done, erase, expose, convert, read, ramp_code, out_data, out_idx, out_valid} !== 28'd0)
            $display("FAIL abort_hold: got timeout=%0d outs=%h want 0 0", to,
                     {busy, frame_done, erase, expose, convert, read, ramp_code, out_data, out_idx, out_valid});
        else passes++;
        kick(16'd3);
        observe_frame(-1, 0, 0);
        checks++; if (n_done !== 1 || n_hs !== 4 || hs_data[2] !== 8'd200 || done_cyc !== 273)
            $display("FAIL frame_after_abort: got done=%0d hs=%0d d2=%0d cyc=%0d want 1 4 200 273",
                     n_done, n_hs, hs_data[2], done_cyc);
        else passes++;
    endtask

    task automatic test_async_reset();
        int to = 1;
        kick(16'd3);
        for (int c = 0; c < 300; c++) begin
            if (convert && ramp_code == 8'd20) begin to = 0; break; end
            @(negedge clk);
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if (to || {busy, frame_done, erase, expose, convert, read, ramp_code, out_data, out_idx, out_valid} !== 28'd0)
            $display("FAIL async_reset: got timeout=%0d outs=%h want 0 0", to,
                     {busy, frame_done, erase, expose, convert, read, ramp_code, out_data, out_idx, out_valid});
        else passes++;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checks++; if (busy !== 1'b0 || convert !== 1'b0)
            $display("FAIL no_resume: got busy=%b convert=%b want 0 0", busy, convert); else passes++;
    endtask

    initial begin
        test_reset();
        test_full_frame();
        test_backpressure();
        test_zero_expose();
        test_abort();
        test_async_reset();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
